// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage with a 2-entry in-order buffer.
//
// The fetch pointer (fpc) addresses an instruction memory that returns the
// word combinationally in the same cycle. Fetched {pc, instr} pairs are queued
// in a two-slot circular buffer. The head is presented to the consumer with a
// valid/ready handshake. A branch redirect flushes the buffer and reloads fpc.
//
// Ports:
//   clk       - sole clock; all state updates on the rising edge
//   rst       - synchronous active-high reset
//   fetch_en  - fetch permitted this cycle
//   im_addr   - word address to instruction memory (straight from fpc)
//   im_data   - instruction word at im_addr (same-cycle)
//   br_taken  - redirect request; flushes buffer, loads fpc from br_addr
//   br_addr   - redirect target word address
//   ir_valid  - head entry valid
//   ir_data   - head instruction word (0 when empty)
//   ir_pc     - head instruction address (0 when empty)
//   ir_ready  - consumer accepts head when ir_valid & ir_ready
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [15:0] im_addr,
    input  logic [31:0] im_data,
    input  logic        br_taken,
    input  logic [15:0] br_addr,
    output logic        ir_valid,
    output logic [31:0] ir_data,
    output logic [15:0] ir_pc,
    input  logic        ir_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] fpc_reg, fpc_next;
    logic        head_reg, head_next;
    logic        tail;
    logic        push;
    logic        pop;

    logic [15:0] pc_mem    [2];
    logic [31:0] instr_mem [2];

    assign im_addr = fpc_reg;

    always_comb begin
        state_next = state_reg;
        fpc_next   = fpc_reg;
        head_next  = head_reg;

        ir_valid = (state_reg != EMPTY);
        ir_pc    = ir_valid ? pc_mem[head_reg]    : 16'h0000;
        ir_data  = ir_valid ? instr_mem[head_reg] : 32'h0000_0000;

        pop  = ir_valid & ir_ready;
        push = fetch_en & ~br_taken & ((state_reg != FULL) | pop);

        // Tail slot = head + occupancy (mod 2). In FULL with a simultaneous
        // pop, the freed head slot becomes the new tail.
        tail = (state_reg == ONE) ? ~head_reg : head_reg;

        if (br_taken) begin
            // Redirect: drop everything buffered (a concurrent pop is simply
            // consumed along with the rest) and restart at the target.
            state_next = EMPTY;
            head_next  = 1'b0;
            fpc_next   = br_addr;
        end else begin
            if (push) begin
                fpc_next = fpc_reg + 16'd1;
            end
            if (pop) begin
                head_next = ~head_reg;
            end
            case (state_reg)
                EMPTY: begin
                    if (push) begin
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_next = FULL;
                    end else if (pop && !push) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (pop && !push) begin
                        state_next = ONE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            fpc_reg   <= RESET_PC;
            head_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            fpc_reg   <= fpc_next;
            head_reg  <= head_next;
        end
    end

    // Buffer storage needs no reset: contents are masked while EMPTY.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[tail]    <= fpc_reg;
            instr_mem[tail] <= im_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed vectors with literal expectations plus a
// queue-based reference model compared against the DUT on every cycle.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [15:0] im_addr;
    logic [31:0] im_data;
    logic        br_taken;
    logic [15:0] br_addr;
    logic        ir_valid;
    logic [31:0] ir_data;
    logic [15:0] ir_pc;
    logic        ir_ready;

    int pass_cnt  = 0;
    int total_cnt = 0;

    instr_fetch #(.RESET_PC(16'h0000)) dut (
        .clk      (clk),
        .rst      (rst),
        .fetch_en (fetch_en),
        .im_addr  (im_addr),
        .im_data  (im_data),
        .br_taken (br_taken),
        .br_addr  (br_addr),
        .ir_valid (ir_valid),
        .ir_data  (ir_data),
        .ir_pc    (ir_pc),
        .ir_ready (ir_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: IM[k] = k + 0x100
    function automatic logic [31:0] im_word(input logic [15:0] a);
        return 32'h0000_0100 + {16'h0000, a};
    endfunction

    assign im_data = im_word(im_addr);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: queue of fetched {pc, instr} pairs plus a fetch pointer.
    typedef struct {
        logic [15:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] mfpc;
    bit          model_live = 0;

    always @(posedge clk) begin
        bit do_pop;
        bit do_push;
        if (rst) begin
            mq.delete();
            mfpc = 16'h0000;
            model_live = 1;
        end else if (br_taken) begin
            mq.delete();
            mfpc = br_addr;
        end else begin
            do_pop  = (mq.size() > 0) && ir_ready;
            do_push = fetch_en && ((mq.size() < 2) || do_pop);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                mq.push_back('{mfpc, im_word(mfpc)});
                mfpc = mfpc + 16'd1;
            end
        end
    end

    always @(negedge clk) begin
        bit ev;
        if (model_live) begin
            ev = (mq.size() > 0);
            check("cmp_im_addr", {16'h0, im_addr}, {16'h0, mfpc});
            check("cmp_ir_valid", {31'h0, ir_valid}, {31'h0, ev});
            check("cmp_ir_pc", {16'h0, ir_pc}, ev ? {16'h0, mq[0].pc} : 32'h0);
            check("cmp_ir_data", ir_data, ev ? mq[0].ins : 32'h0);
            if (ir_valid && ir_ready && !rst && !br_taken)
                $display("accept pc=%h data=%h", ir_pc, ir_data);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; br_taken = 1'b0; br_addr = 16'h0; ir_ready = 1'b0;
        cyc(); cyc();
        check("rst_valid", {31'h0, ir_valid}, 32'h0);
        check("rst_im_addr", {16'h0, im_addr}, 32'h0);
        check("rst_ir_pc", {16'h0, ir_pc}, 32'h0);
        check("rst_ir_data", ir_data, 32'h0);

        // Streaming from reset: one instruction per cycle, first one cycle after release
        rst = 1'b0; fetch_en = 1'b1; ir_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("stream_valid", {31'h0, ir_valid}, 32'h1);
            check("stream_pc", {16'h0, ir_pc}, k);
            check("stream_data", ir_data, 32'h100 + k);
        end

        // Back-pressure: buffer fills, im_addr stalls at 2, head holds 0
        rst = 1'b1; cyc();
        rst = 1'b0; fetch_en = 1'b1; ir_ready = 1'b0;
        cyc();
        check("bp_one_im_addr", {16'h0, im_addr}, 32'h1);
        cyc();
        check("bp_full_im_addr", {16'h0, im_addr}, 32'h2);
        cyc();
        check("bp_hold_im_addr", {16'h0, im_addr}, 32'h2);
        check("bp_hold_pc", {16'h0, ir_pc}, 32'h0);
        ir_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            cyc();
            check("bp_release_pc", {16'h0, ir_pc}, k);
            check("bp_release_valid", {31'h0, ir_valid}, 32'h1);
        end

        // Redirect while FULL with a concurrent pop
        br_taken = 1'b1; br_addr = 16'h0040;
        cyc();
        check("br_flush_valid", {31'h0, ir_valid}, 32'h0);
        check("br_im_addr", {16'h0, im_addr}, 32'h40);
        br_taken = 1'b0;
        cyc();
        check("br_target_valid", {31'h0, ir_valid}, 32'h1);
        check("br_target_pc", {16'h0, ir_pc}, 32'h40);
        check("br_target_data", ir_data, 32'h140);

        // Address wrap at 16'hFFFF
        br_taken = 1'b1; br_addr = 16'hFFFE;
        cyc();
        check("wrap_im_addr", {16'h0, im_addr}, 32'hFFFE);
        br_taken = 1'b0;
        cyc(); check("wrap_pc0", {16'h0, ir_pc}, 32'hFFFE); check("wrap_d0", ir_data, 32'h100FE);
        cyc(); check("wrap_pc1", {16'h0, ir_pc}, 32'hFFFF); check("wrap_d1", ir_data, 32'h100FF);
        cyc(); check("wrap_pc2", {16'h0, ir_pc}, 32'h0000); check("wrap_d2", ir_data, 32'h100);
        cyc(); check("wrap_pc3", {16'h0, ir_pc}, 32'h0001);

        // fetch_en low: drain to EMPTY, fpc frozen, resume at frozen address
        fetch_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("stall_valid", {31'h0, ir_valid}, 32'h0);
            check("stall_im_addr", {16'h0, im_addr}, 32'h2);
        end
        fetch_en = 1'b1;
        cyc(); check("resume_pc0", {16'h0, ir_pc}, 32'h2);
        cyc(); check("resume_pc1", {16'h0, ir_pc}, 32'h3);

        // Reset beats a simultaneous redirect
        rst = 1'b1; br_taken = 1'b1; br_addr = 16'h1234;
        cyc();
        check("rstbr_valid", {31'h0, ir_valid}, 32'h0);
        check("rstbr_im_addr", {16'h0, im_addr}, 32'h0);
        rst = 1'b0; br_taken = 1'b0;
        cyc();
        check("rstbr_first_pc", {16'h0, ir_pc}, 32'h0);
        check("rstbr_first_data", ir_data, 32'h100);

        // Redirect with fetch_en low still takes effect
        fetch_en = 1'b0; ir_ready = 1'b0; br_taken = 1'b1; br_addr = 16'h0200;
        cyc();
        check("brnofe_im_addr", {16'h0, im_addr}, 32'h200);
        check("brnofe_valid", {31'h0, ir_valid}, 32'h0);
        br_taken = 1'b0;
        cyc();
        check("brnofe_hold_addr", {16'h0, im_addr}, 32'h200);
        fetch_en = 1'b1;
        cyc();
        check("brnofe_pc", {16'h0, ir_pc}, 32'h200);
        check("brnofe_data", ir_data, 32'h300);

        // Mixed random traffic, checked by the model every cycle
        for (int k = 0; k < 300; k++) begin
            fetch_en = ($urandom_range(0, 3) != 0);
            ir_ready = ($urandom_range(0, 2) != 0);
            br_taken = ($urandom_range(0, 15) == 0);
            br_addr  = 16'($urandom);
            rst      = ($urandom_range(0, 63) == 0);
            cyc();
        end
        rst = 1'b0; br_taken = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
